// File: rtl/uart_word_assembler.sv
// Packs WORD_BYTES UART bytes into one word; word_valid rises the cycle after the final byte.
// One output word plus one held word of buffering; bytes arriving while a word is held are dropped (overflow).
module uart_word_assembler #(
   parameter int WORD_BYTES     = 8,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [7:0]                           in_data,
   input  logic                                 in_valid,
   output logic [8*WORD_BYTES-1:0]              word_data,
   output logic                                 word_valid,
   input  logic                                 word_ready,
   output logic [$clog2(WORD_BYTES+1)-1:0]      byte_count,
   output logic                                 overflow,
   output logic                                 frame_timeout,
   input  logic                                 clr_err
);
   localparam int W   = 8*WORD_BYTES;
   localparam int BCW = $clog2(WORD_BYTES+1);
   localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;
   localparam logic [BCW-1:0] LAST = BCW'(WORD_BYTES-1);
   localparam logic [BCW-1:0] FULL = BCW'(WORD_BYTES);
   localparam logic [TCW-1:0] TLIM = TCW'(TIMEOUT_CYCLES);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   acc, acc_nxt, acc_shift;
   logic [TCW-1:0] tcnt, tcnt_nxt;
   logic [W-1:0]   wd_nxt;
   logic           wv_nxt, ov_nxt, ft_nxt;
   logic [BCW-1:0] bc_nxt;
   logic           slot_free, hs;

   assign acc_shift = MSB_FIRST ? {acc[W-9:0], in_data} : {in_data, acc[W-1:8]};
   assign hs        = word_valid && word_ready;
   assign slot_free = !word_valid || word_ready;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      tcnt_nxt  = tcnt;
      wd_nxt    = word_data;
      wv_nxt    = word_valid;
      bc_nxt    = byte_count;
      ft_nxt    = 1'b0;
      ov_nxt    = clr_err ? 1'b0 : overflow;
      case (state)
         COLLECT: begin
            if (hs) wv_nxt = 1'b0;
            if (in_valid) begin
               tcnt_nxt = '0;
               if (byte_count == LAST) begin
                  if (slot_free) begin
                     wd_nxt  = acc_shift;
                     wv_nxt  = 1'b1;
                     acc_nxt = '0;
                     bc_nxt  = '0;
                  end else begin
                     acc_nxt   = acc_shift;
                     bc_nxt    = FULL;
                     state_nxt = HOLD;
                  end
               end else begin
                  acc_nxt = acc_shift;
                  bc_nxt  = byte_count + 1'b1;
               end
            end else if (byte_count != '0 && TIMEOUT_CYCLES != 0) begin
               // Stale partial word: drop it once the idle gap reaches the limit.
               if (tcnt == TLIM - 1'b1) begin
                  acc_nxt  = '0;
                  bc_nxt   = '0;
                  tcnt_nxt = '0;
                  ft_nxt   = 1'b1;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
         end
         HOLD: begin
            if (in_valid) ov_nxt = 1'b1;
            if (hs) begin
               wd_nxt    = acc;
               acc_nxt   = '0;
               bc_nxt    = '0;
               state_nxt = COLLECT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= COLLECT;
         acc           <= '0;
         tcnt          <= '0;
         word_data     <= '0;
         word_valid    <= 1'b0;
         byte_count    <= '0;
         overflow      <= 1'b0;
         frame_timeout <= 1'b0;
      end else begin
         state         <= state_nxt;
         acc           <= acc_nxt;
         tcnt          <= tcnt_nxt;
         word_data     <= wd_nxt;
         word_valid    <= wv_nxt;
         byte_count    <= bc_nxt;
         overflow      <= ov_nxt;
         frame_timeout <= ft_nxt;
      end
   end
endmodule

// File: tb/tb_uart_word_assembler.sv
// Two assembler instances (8-byte MSB-first, 4-byte LSB-first) on shared stimulus, checked against a byte-list model.
module tb_uart_word_assembler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, word_ready, clr_err;
   logic [7:0]  in_data;
   logic [63:0] wd_a;
   logic [31:0] wd_b;
   logic        wv_a, wv_b, ov_a, ov_b, ft_a, ft_b;
   logic [3:0]  bc_a;
   logic [2:0]  bc_b;

   int checks = 0;
   int failures = 0;

   uart_word_assembler #(.WORD_BYTES(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(20)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .word_data(wd_a), .word_valid(wv_a), .word_ready(word_ready),
      .byte_count(bc_a), .overflow(ov_a), .frame_timeout(ft_a), .clr_err(clr_err));

   uart_word_assembler #(.WORD_BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(7)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .word_data(wd_b), .word_valid(wv_b), .word_ready(word_ready),
      .byte_count(bc_b), .overflow(ov_b), .frame_timeout(ft_b), .clr_err(clr_err));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: each instance keeps the list of bytes of its partial word and a single output slot.
   function automatic int wbm(input int i); return (i == 0) ? 8 : 4; endfunction
   function automatic int tom(input int i); return (i == 0) ? 20 : 7; endfunction
   function automatic bit msbm(input int i); return i == 0; endfunction

   logic [7:0]  pb [2][8];
   int          pc [2];
   int          idle [2];
   bit          mv [2], mov [2], mft [2];
   logic [63:0] md [2];

   function automatic logic [63:0] pack(input int i);
      logic [63:0] w = 64'd0;
      for (int k = 0; k < wbm(i); k++) begin
         if (msbm(i)) w = w | (64'(pb[i][k]) << (8*(wbm(i)-1-k)));
         else         w = w | (64'(pb[i][k]) << (8*k));
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         pc[i] = 0; idle[i] = 0; mv[i] = 0; mov[i] = 0; mft[i] = 0; md[i] = 64'd0;
      end
   endtask

   task automatic model_step(input int i);
      bit hs;
      hs = mv[i] && word_ready;
      mft[i] = 0;
      if (pc[i] == wbm(i)) begin
         if (in_valid) mov[i] = 1;
         else if (clr_err) mov[i] = 0;
         if (hs) begin md[i] = pack(i); pc[i] = 0; end
      end else begin
         if (clr_err) mov[i] = 0;
         if (hs) mv[i] = 0;
         if (in_valid) begin
            pb[i][pc[i]] = in_data;
            pc[i]++;
            idle[i] = 0;
            if (pc[i] == wbm(i) && !mv[i]) begin md[i] = pack(i); mv[i] = 1; pc[i] = 0; end
         end else if (pc[i] > 0) begin
            idle[i]++;
            if (tom(i) != 0 && idle[i] == tom(i)) begin pc[i] = 0; idle[i] = 0; mft[i] = 1; end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin model_step(0); model_step(1); end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("a_valid", 64'(wv_a), 64'(mv[0]));
         chk("a_data",  wd_a,      md[0]);
         chk("a_count", 64'(bc_a), 64'(pc[0]));
         chk("a_ovf",   64'(ov_a), 64'(mov[0]));
         chk("a_tmo",   64'(ft_a), 64'(mft[0]));
         chk("b_valid", 64'(wv_b), 64'(mv[1]));
         chk("b_data",  64'(wd_b), md[1]);
         chk("b_count", 64'(bc_b), 64'(pc[1]));
         chk("b_ovf",   64'(ov_b), 64'(mov[1]));
         chk("b_tmo",   64'(ft_b), 64'(mft[1]));
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic send(input logic [7:0] b);
      in_data = b; in_valid = 1'b1; tick(); in_valid = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; word_ready = 1'b0; clr_err = 1'b0;
      do_reset();
      chk("rst_valid", 64'(wv_a), 64'd0);
      chk("rst_data",  wd_a, 64'd0);
      chk("rst_count", 64'(bc_a), 64'd0);

      // Bytes 01..08 with consumer ready.
      word_ready = 1'b1;
      for (int b = 1; b <= 8; b++) begin
         send(8'(b));
         if (b < 8) chk("a_early_valid", 64'(wv_a), 64'd0);
      end
      chk("a_word_msb",   wd_a, 64'h0102030405060708);
      chk("model_a_word", md[0], 64'h0102030405060708);
      chk("a_word_vld",   64'(wv_a), 64'd1);
      chk("a_word_cnt",   64'(bc_a), 64'd0);
      chk("b_word_lsb",   64'(wd_b), 64'h08070605);
      chk("model_b_word", md[1], 64'h08070605);
      tick();
      chk("a_consumed", 64'(wv_a), 64'd0);

      // Final byte of the next word coincides with the handshake of the current one.
      word_ready = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (b == 7) word_ready = 1'b1;
         send(8'(b));
         if (b >= 3) chk("b_no_bubble", 64'(wv_b), 64'd1);
      end
      chk("b_b2b_word", 64'(wd_b), 64'h07060504);
      chk("a_b2b_word", wd_a, 64'h0001020304050607);
      tick();

      // Backpressure: one word out, one held, 17th byte dropped.
      do_reset();
      word_ready = 1'b0;
      for (int b = 0; b <= 16; b++) send(8'(b));
      chk("ovf_word0", wd_a, 64'h0001020304050607);
      chk("ovf_count", 64'(bc_a), 64'd8);
      chk("ovf_flag",  64'(ov_a), 64'd1);
      word_ready = 1'b1;
      tick();
      chk("ovf_word1", wd_a, 64'h08090A0B0C0D0E0F);
      chk("ovf_word1_vld", 64'(wv_a), 64'd1);
      tick();
      tick();
      chk("ovf_drained", 64'(wv_a), 64'd0);
      chk("ovf_sticky", 64'(ov_a), 64'd1);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("ovf_cleared", 64'(ov_a), 64'd0);

      // Inter-byte timeout.
      do_reset();
      word_ready = 1'b1;
      send(8'h31); send(8'h32); send(8'h33);
      n = 0;
      while (n < 60 && !ft_a) begin tick(); n++; end
      chk("tmo_delay", 64'(n), 64'd20);
      chk("tmo_count", 64'(bc_a), 64'd0);
      for (int b = 0; b < 8; b++) send(8'hA0 + 8'(b));
      chk("tmo_next_word", wd_a, 64'hA0A1A2A3A4A5A6A7);
      tick();

      // Reset mid-word.
      for (int b = 0; b < 5; b++) send(8'h50 + 8'(b));
      rst_n = 1'b0;
      #2;
      chk("arst_data",  wd_a, 64'd0);
      chk("arst_count", 64'(bc_a), 64'd0);
      chk("arst_valid", 64'(wv_a), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      for (int b = 0; b < 8; b++) send(8'h11 + 8'(b));
      chk("arst_clean_word", wd_a, 64'h1112131415161718);
      tick();

      // Randomized traffic with varying byte density and consumer readiness.
      for (int seg = 0; seg < 30; seg++) begin
         int vp, rp;
         case ($urandom_range(0, 3))
            0: vp = 90;
            1: vp = 30;
            2: vp = 4;
            default: vp = 60;
         endcase
         rp = $urandom_range(10, 100);
         for (int c = 0; c < 100; c++) begin
            in_valid   = ($urandom_range(0, 99) < vp);
            in_data    = 8'($urandom);
            word_ready = ($urandom_range(0, 99) < rp);
            clr_err    = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
      end
      in_valid = 1'b0; clr_err = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
